// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq.
//   in_valid/in_ready   : operand-side handshake (a, b, alu_ctrl)
//   out_valid/out_ready : result-side handshake (result, flag_z/n/c/v)
// master = producer of operations / consumer of results, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, a, b, alu_ctrl, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, a, b, alu_ctrl, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with NZCV flags and a multi-cycle shift-add multiplier.
// One operation in flight; IDLE -> (BUSY for MUL) -> DONE -> IDLE.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high; returns to IDLE and clears result/flags
//   bus   : alu_seq_if slave modport (operand and result handshakes)
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;

  // Single-cycle datapath
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          add_w, sub_w;
  logic [2*WIDTH-1:0]      shl_w;
  logic [SW-1:0]           shamt;
  logic [WIDTH-1:0]        alu_r;
  logic                    alu_c, alu_v;
  logic [2*WIDTH-1:0]      acc_nxt;

  assign a_s   = bus.a;
  assign b_s   = bus.b;
  assign shamt = bus.b[SW-1:0];

  always_comb begin
    add_w = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    // Double-width shift: bit WIDTH of the result is a[WIDTH-shamt], i.e. the
    // last bit pushed out of the narrow result (and 0 when shamt == 0).
    shl_w = {{WIDTH{1'b0}}, bus.a} << shamt;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.alu_ctrl)
      OP_ADD: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];  // carry set means no borrow
        alu_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_r = bus.a & bus.b;
      OP_OR:  alu_r = bus.a | bus.b;
      OP_XOR: alu_r = bus.a ^ bus.b;
      OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SHL: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = (shamt != '0) ? shl_w[WIDTH] : 1'b0;
      end
      default: ;
    endcase
  end

  // MSB-first shift-add: acc = 2*acc + (b[i] ? a : 0) for i = WIDTH-1..0
  assign acc_nxt = {acc_q[2*WIDTH-2:0], 1'b0}
                 + (mb_q[cnt_q] ? {{WIDTH{1'b0}}, ma_q} : {(2*WIDTH){1'b0}});

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.alu_ctrl == OP_MUL) begin
            ma_d    = bus.a;
            mb_d    = bus.b;
            acc_d   = '0;
            cnt_d   = SW'(WIDTH - 1);
            state_d = S_BUSY;
          end else begin
            result_d = alu_r;
            z_d      = (alu_r == '0);
            n_d      = alu_r[WIDTH-1];
            c_d      = alu_c;
            v_d      = alu_v;
            state_d  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        acc_d = acc_nxt;
        if (cnt_q == '0) begin
          result_d = acc_nxt[WIDTH-1:0];
          z_d      = (acc_nxt[WIDTH-1:0] == '0);
          n_d      = acc_nxt[WIDTH-1];
          c_d      = (acc_nxt[2*WIDTH-1:WIDTH] != '0);
          v_d      = 1'b0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
    end
  end

  // Multiplier operands and accumulator are reloaded on every MUL acceptance.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    ma_q  <= ma_d;
    mb_q  <= mb_d;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: {result[7:0], z, n, c, v} from plain integer arithmetic.
  function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, full, r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      3'd0: begin full = ua + ub; r = full % 256; c = (full > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin r = (ua - ub + 256) % 256; c = (ua >= ub); v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: begin full = ua * (1 << (ub % 8)); r = full % 256; c = ((full / 256) % 2) == 1; end
      default: begin full = ua * ub; r = full % 256; c = (full > 255); end
    endcase
    model = {r[7:0], (r == 0), (r > 127), c, v};
  endfunction

  function automatic logic [3:0] flags();
    flags = {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
  endfunction

  // Issue one op, check latency, result and flags against the model, optionally
  // stall the consumer for 'stall' cycles, then release and check return to IDLE.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int stall, output logic [7:0] r_o, output logic [3:0] f_o);
    logic [11:0] exp;
    int n;
    exp = model(op, a, b);
    n = 0;
    while (!bus.in_ready && n < 30) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("accepted", 32'(bus.in_ready), 32'd0);
    // latency counted in clock edges after the acceptance edge
    n = 0;
    while (!bus.out_valid && n < 40) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("latency", 32'(n), (op == 3'd7) ? 32'(W) : 32'd0);
    r_o = bus.result;
    f_o = flags();
    chk("result", 32'(bus.result), 32'(exp[11:4]));
    chk("flags_zncv", 32'(flags()), 32'(exp[3:0]));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 3'($urandom);
      bus.a        = 8'($urandom);
      @(posedge clk); #1;
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_result", 32'(bus.result), 32'(exp[11:4]));
      chk("stall_flags", 32'(flags()), 32'(exp[3:0]));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
  endtask

  logic [7:0] r;
  logic [3:0] f;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.alu_ctrl  = '0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'(flags()), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-MUL, asserted during the third BUSY cycle
    bus.in_valid = 1'b1; bus.alu_ctrl = 3'd7; bus.a = 8'h0D; bus.b = 8'h0B;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_mul_busy", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_result", 32'(bus.result), 32'd0);
    chk("mrst_flags", 32'(flags()), 32'd0);

    // Directed vectors; flags packed as {Z,N,C,V}
    run_op(3'd0, 8'hBD, 8'hA5, 0, r, f);
    chk("add_r", 32'(r), 32'h62); chk("add_f", 32'(f), 32'b0011);
    run_op(3'd1, 8'hBD, 8'hA5, 0, r, f);
    chk("sub_r", 32'(r), 32'h18); chk("sub_f", 32'(f), 32'b0010);
    run_op(3'd7, 8'h0D, 8'h0B, 0, r, f);
    chk("mul_r", 32'(r), 32'h8F); chk("mul_f", 32'(f), 32'b0100);
    run_op(3'd7, 8'h20, 8'h10, 0, r, f);
    chk("mul2_r", 32'(r), 32'h00); chk("mul2_f", 32'(f), 32'b1010);
    run_op(3'd6, 8'h81, 8'h09, 0, r, f);
    chk("shl_r", 32'(r), 32'h02); chk("shl_c", 32'(f[1]), 32'd1);
    run_op(3'd5, 8'hFB, 8'h05, 0, r, f);
    chk("slt1_r", 32'(r), 32'h01);
    run_op(3'd5, 8'h05, 8'hFB, 0, r, f);
    chk("slt0_r", 32'(r), 32'h00); chk("slt0_z", 32'(f[3]), 32'd1);
    run_op(3'd2, 8'hBD, 8'hA5, 5, r, f);
    chk("and_r", 32'(r), 32'hA5);

    // Back-to-back with in_valid held high: acceptance on alternate cycles
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.alu_ctrl = 3'd4; bus.a = 8'hFF; bus.b = 8'h0F;
    @(posedge clk); #1;
    chk("b2b_xor_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_xor_r", 32'(bus.result), 32'hF0);
    chk("b2b_xor_f", 32'(flags()), 32'b0100);
    bus.alu_ctrl = 3'd3; bus.a = 8'h00; bus.b = 8'h00;
    @(posedge clk); #1;
    chk("b2b_gap", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_or_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_or_r", 32'(bus.result), 32'h00);
    chk("b2b_or_f", 32'(flags()), 32'b1000);
    @(posedge clk); #1;

    // Randomized operations with random consumer stalls
    for (int k = 0; k < 60; k++) begin
      run_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), r, f);
    end
    // Boundary SHL amounts and MUL extremes
    run_op(3'd6, 8'hFF, 8'h00, 0, r, f);
    run_op(3'd6, 8'h01, 8'h07, 0, r, f);
    run_op(3'd6, 8'h02, 8'hFF, 0, r, f);
    run_op(3'd7, 8'hFF, 8'hFF, 0, r, f);
    run_op(3'd7, 8'h00, 8'hFF, 0, r, f);
    run_op(3'd0, 8'h7F, 8'h01, 0, r, f);
    run_op(3'd1, 8'h80, 8'h01, 0, r, f);
    run_op(3'd1, 8'h00, 8'h01, 0, r, f);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational alu.
- Adds a 3-bit opcode set (XOR, SLT, SHL and a multi-cycle shift-add MUL) and a full NZCV flag set.
- Uses valid/ready handshakes on both the operand side and the result side.
- Sits between the operand/decode stage and writeback; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2. Shift amount width SW = $clog2(WIDTH).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- alu_ctrl  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SHL, 111 MUL
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- flag_z  out  1  result == 0
- flag_n  out  1  result[WIDTH-1]
- flag_c  out  1  carry, per-opcode rule below
- flag_v  out  1  signed overflow, per-opcode rule below

Behaviour:
- States: IDLE, BUSY, DONE. Reset (sync, highest priority, also mid-BUSY/DONE) -> IDLE.
  - Reset clears result, all flags, out_valid and the multiplier count to 0; in_ready = 1 after reset.
  - Any in-flight MUL or unconsumed result is discarded on reset.
- in_ready = (state == IDLE), combinational from state. out_valid = (state == DONE).
- IDLE, in_valid=1, opcode != MUL: compute combinationally and register result and flags; go to DONE. out_valid rises one cycle after acceptance.
- IDLE, in_valid=1, opcode MUL: latch a, b; clear the 2*WIDTH accumulator; go to BUSY.
  - BUSY performs exactly WIDTH shift-add iterations, one per clock, on a WIDTH-1..0 counter.
  - The last iteration writes result/flags and moves to DONE. out_valid rises WIDTH cycles after the acceptance edge.
  - in_valid and operand changes during BUSY are ignored.
- DONE: result and flags held stable while out_ready=0. out_ready=1 -> IDLE next edge.
  - No new operation is accepted in the DONE-to-IDLE cycle, so peak throughput is 1 op per 2 cycles for non-MUL ops.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: result = a+b; C = carry out of bit WIDTH-1; V = a,b same sign and result sign differs.
  - SUB: result = a+~b+1; C = 1 iff no borrow (a >= b unsigned); V = a,b differ in sign and result sign != a sign.
  - AND/OR/XOR: bitwise; C = 0, V = 0.
  - SLT: result = {0..., (signed a < signed b)}; C = 0, V = 0.
  - SHL: shamt = b[SW-1:0]; upper bits of b ignored; result = a << shamt.
    - C = a[WIDTH-shamt] (last bit shifted out) when shamt > 0, else 0. V = 0.
  - MUL: unsigned product; result = low WIDTH bits; C = 1 iff the high WIDTH bits are nonzero; V = 0.
- Z and N always derive from the registered result.

Test Plan:
- Reset mid-MUL: accept MUL 0x0D*0x0B; assert reset on 3rd BUSY cycle -> next cycle in_ready=1, out_valid=0, result=0x00, all flags 0.
- ADD a=0xBD b=0xA5 -> out_valid 1 cycle after accept; result=0x62, C=1, V=1, Z=0, N=0. SUB same operands -> 0x18, C=1, V=0.
- MUL a=0x0D b=0x0B -> out_valid exactly 8 cycles after accept; result=0x8F, C=0, N=1. MUL a=0x20 b=0x10 -> result=0x00, Z=1, C=1.
- SHL a=0x81 b=0x09 (shamt 1) -> 0x02, C=1. SLT a=0xFB b=0x05 -> 0x01; SLT a=0x05 b=0xFB -> 0x00, Z=1.
- Backpressure: AND 0xBD,0xA5 -> 0xA5; hold out_ready=0 for 5 cycles -> result, flags and out_valid stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next cycle.
- Back-to-back with out_ready=1 and in_valid held high: XOR 0xFF,0x0F then OR 0x00,0x00 -> accepted on alternate cycles; results 0xF0 (N=1) then 0x00 (Z=1), C=V=0.
